// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx : 24-bit stereo I2S deserializer, single bit-clock domain (bick).
//
// Samples sdto on bick rising edges. Word select lrck frames the stream:
// a falling lrck edge starts a left half-frame and a rising edge starts a
// right half-frame. One left word and one right word are assembled per
// frame and published together.
//
// Ports
//   bick        in   serial bit clock, all logic on its rising edge
//   reset       in   asynchronous active-low reset
//   lrck        in   word select, 0 = left, 1 = right
//   start       in   capture enable (level); 0 forces IDLE and flushes state
//   sdto        in   serial data, MSB first
//   data_left   out  last complete left word (24-bit two's complement)
//   data_right  out  last complete right word
//   stop        out  one-cycle frame-complete pulse
//   fsm_state   out  current FSM state (debug observation)
//
// Handshake: stop is a valid-only strobe with no ready; data_left and
// data_right change only on the edge that raises stop and hold otherwise,
// so a consumer may sample them in the cycle stop is high or any time later.
//
// Build option: I2S_LEFT_JUSTIFIED_EN selects left-justified framing
// (no one-bit delay slot after the lrck edge). Default is standard I2S.
// ---------------------------------------------------------------------------
module i2s_rx (
  input  logic        bick,
  input  logic        reset,
  input  logic        lrck,
  input  logic        start,
  input  logic        sdto,
  output logic [23:0] data_left,
  output logic [23:0] data_right,
  output logic        stop,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DELAY = 3'd2,
    SHIFT = 3'd3,
    WAIT  = 3'd4
  } state_t;

  // State entered after an lrck edge: the delay slot for I2S, or straight
  // into capture for left-justified framing.
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam state_t HALF_START = SHIFT;
`else
  localparam state_t HALF_START = DELAY;
`endif

  state_t      state;
  logic        lrck_d;
  logic [4:0]  bit_cnt;
  logic [23:0] shift_reg;
  logic [23:0] left_shadow;
  logic        pend_left;
  logic        chan;        // channel of the current half-frame, 1 = right

  logic        lrck_edge;
  logic        lrck_fall;
  logic [23:0] word_next;

  assign lrck_edge = lrck ^ lrck_d;
  assign lrck_fall = lrck_edge & ~lrck;
  assign word_next = {shift_reg[22:0], sdto};
  assign fsm_state = state;

  always_ff @(posedge bick or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lrck_d      <= 1'b0;
      bit_cnt     <= 5'd0;
      shift_reg   <= 24'd0;
      left_shadow <= 24'd0;
      pend_left   <= 1'b0;
      chan        <= 1'b0;
      data_left   <= 24'd0;
      data_right  <= 24'd0;
      stop        <= 1'b0;
    end else begin
      lrck_d <= lrck;
      stop   <= 1'b0;
      if (!start) begin
        state     <= IDLE;
        bit_cnt   <= 5'd0;
        shift_reg <= 24'd0;
        pend_left <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;

          // Only a falling edge synchronises, so capture always begins with
          // a left word and frames pair up as left-then-right.
          SYNC: begin
            if (lrck_fall) begin
              state   <= HALF_START;
              chan    <= 1'b0;
              bit_cnt <= 5'd0;
            end
          end

          DELAY: begin
            state   <= SHIFT;
            bit_cnt <= 5'd0;
          end

          SHIFT: begin
            if (bit_cnt == 5'd23) begin
              // Final bit completes the word even if the next half-frame's
              // edge arrives on the same cycle (minimum-length half-frame).
              shift_reg <= word_next;
              if (!chan) begin
                left_shadow <= word_next;
                pend_left   <= 1'b1;
              end else if (pend_left) begin
                data_left  <= left_shadow;
                data_right <= word_next;
                stop       <= 1'b1;
                pend_left  <= 1'b0;
              end
              if (lrck_edge) begin
                state   <= HALF_START;
                chan    <= lrck;
                bit_cnt <= 5'd0;
              end else begin
                state <= WAIT;
              end
            end else if (lrck_edge) begin
              // Short half-frame: drop the partial word and break the pair.
              state     <= HALF_START;
              chan      <= lrck;
              bit_cnt   <= 5'd0;
              shift_reg <= 24'd0;
              pend_left <= 1'b0;
            end else begin
              shift_reg <= word_next;
              bit_cnt   <= bit_cnt + 5'd1;
            end
          end

          // Bits past the 24th (32/64 bick per half-frame) are ignored.
          WAIT: begin
            if (lrck_edge) begin
              state   <= HALF_START;
              chan    <= lrck;
              bit_cnt <= 5'd0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx : self-checking bench for i2s_rx.
//
// Half-frames are described as a bit stream per bick slot; the reference
// model takes the 24 bits at the receiver's sampling slots after each lrck
// edge and applies the pairing rules (sync on falling edge, short halves
// break the pair, start/reset flush). Expected frames and their stop cycle
// go into a queue checked by a stop monitor.
// Honours I2S_LEFT_JUSTIFIED_EN to match the DUT build.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int FK = 1;  // slot of the MSB after the lrck edge
  localparam logic [23:0] LJ_EXP = 24'hC00003;
`else
  localparam int FK = 2;
  localparam logic [23:0] LJ_EXP = 24'h800006;
`endif

  logic        bick;
  logic        reset;
  logic        lrck;
  logic        start;
  logic        sdto;
  logic [23:0] data_left;
  logic [23:0] data_right;
  logic        stop;
  logic [2:0]  fsm_state;

  i2s_rx dut (
    .bick       (bick),
    .reset      (reset),
    .lrck       (lrck),
    .start      (start),
    .sdto       (sdto),
    .data_left  (data_left),
    .data_right (data_right),
    .stop       (stop),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial bick = 1'b0;
  always #5 bick = ~bick;

  int cyc = 0;
  always @(posedge bick) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] exp_q[$];
  int          exp_t[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge bick) begin
    if (stop) begin
      if (exp_q.size() == 0) begin
        check("unexpected_stop", 32'd1, 32'd0);
      end else begin
        logic [47:0] e;
        int t;
        e = exp_q.pop_front();
        t = exp_t.pop_front();
        check("stop_left", {8'd0, data_left}, {8'd0, e[47:24]});
        check("stop_right", {8'd0, data_right}, {8'd0, e[23:0]});
        check("stop_cycle", cyc, t);
      end
    end
  end

  // ---------------- reference model state ----------------
  logic        cur_lrck = 1'b1;
  bit          m_sync = 0;
  bit          m_pend = 0;
  logic [23:0] m_lval = '0;
  logic [23:0] m_left = '0;
  logic [23:0] m_right = '0;

  // ---------------- driver ----------------
  // ch: channel, len: bick slots in this half-frame, word placed MSB-first
  // starting at slot off; zfill zeroes the non-word slots. drop_at/rst_at
  // (>=0) pull start/reset low for 3 cycles from that slot.
  task automatic send_half(input logic ch, input int len, input logic [23:0] word,
                           input int off, input bit zfill, input int drop_at,
                           input int rst_at);
    logic        b [0:63];
    logic [23:0] cap;
    bit          edge_seen, complete, disrupt;
    int          t0;
    for (int k = 0; k < 64; k++) begin
      if (k >= off && k < off + 24) b[k] = word[23 - (k - off)];
      else b[k] = zfill ? 1'b0 : 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 24; i++) cap[23 - i] = b[FK + i];
    edge_seen = (ch != cur_lrck);
    complete  = (len >= FK + 24);
    disrupt   = (drop_at >= 0) || (rst_at >= 0);
    t0 = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge bick);
      if (k == 0) begin
        t0 = cyc + 1;
        if (disrupt) begin
          m_sync = 0;
          m_pend = 0;
          if (rst_at >= 0) begin
            m_left  = '0;
            m_right = '0;
          end
        end else if (edge_seen) begin
          if (!ch) m_sync = 1;
          if (m_sync) begin
            if (!complete) m_pend = 0;
            else if (!ch) begin
              m_lval = cap;
              m_pend = 1;
            end else if (m_pend) begin
              exp_q.push_back({m_lval, cap});
              exp_t.push_back(t0 + FK + 23);
              m_left  = m_lval;
              m_right = cap;
              m_pend  = 0;
            end
          end
        end
      end
      lrck = ch;
      sdto = b[k];
      if (drop_at >= 0 && k == drop_at) start = 1'b0;
      if (drop_at >= 0 && k == drop_at + 3) start = 1'b1;
      if (rst_at >= 0 && k == rst_at) begin
        reset = 1'b0;
        #1;
        check("rst_left", {8'd0, data_left}, 32'd0);
        check("rst_right", {8'd0, data_right}, 32'd0);
        check("rst_stop", {31'd0, stop}, 32'd0);
      end
      if (rst_at >= 0 && k == rst_at + 3) reset = 1'b1;
    end
    cur_lrck = ch;
    @(posedge bick);
    #1;
    check("hold_left", {8'd0, data_left}, {8'd0, m_left});
    check("hold_right", {8'd0, data_right}, {8'd0, m_right});
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_half(1'b0, 32, l, FK, 1'b0, -1, -1);
    send_half(1'b1, 32, r, FK, 1'b0, -1, -1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    lrck  = 1'b1;
    sdto  = 1'b0;
    #1;
    check("reset_left", {8'd0, data_left}, 32'd0);
    check("reset_right", {8'd0, data_right}, 32'd0);
    check("reset_stop", {31'd0, stop}, 32'd0);
    check("reset_state", {29'd0, fsm_state}, 32'd0);
    @(negedge bick);
    @(negedge bick);
    reset = 1'b1;
    start = 1'b1;
    send_half(1'b1, 4, 24'd0, FK, 1'b0, -1, -1);  // idle, lrck high

    send_frame(24'hA5A5A5, 24'h123456);
    check("tp_a5_left", {8'd0, data_left}, 32'h00A5A5A5);
    check("tp_a5_right", {8'd0, data_right}, 32'h00123456);

    send_frame(24'h800000, 24'h7FFFFF);
    send_frame(24'h000001, 24'hFFFFFF);

    // start dropped mid-left-word, then a full frame
    send_half(1'b0, 32, 24'h111111, FK, 1'b0, 10, -1);
    send_half(1'b1, 32, 24'h222222, FK, 1'b0, -1, -1);
    send_frame(24'h333333, 24'h444444);

    // right half-frame with only 20 bits
    send_half(1'b0, 32, 24'h555555, FK, 1'b0, -1, -1);
    send_half(1'b1, FK + 20, 24'h666666, FK, 1'b0, -1, -1);
    send_frame(24'h777777, 24'h888888);

    // reset mid-right-word
    send_half(1'b0, 32, 24'h999999, FK, 1'b0, -1, -1);
    send_half(1'b1, 32, 24'hAAAAAA, FK, 1'b0, -1, 12);
    send_frame(24'hBBBBBB, 24'hCCCCCC);

    // left-justified stimulus: MSB in the first slot after the edge
    send_half(1'b0, 32, 24'hC00003, 1, 1'b1, -1, -1);
    send_half(1'b1, 32, 24'h0F0F0F, 1, 1'b1, -1, -1);
    check("lj_left", {8'd0, data_left}, {8'd0, LJ_EXP});

    // randomized frames, varying half-frame lengths, occasional short halves
    for (int f = 0; f < 24; f++) begin
      for (int h = 0; h < 2; h++) begin
        int len;
        if ($urandom_range(0, 7) == 0) len = FK + $urandom_range(4, 20);
        else len = $urandom_range(FK + 24, 40);
        send_half(h[0], len, 24'($urandom()), FK, 1'b0, -1, -1);
      end
    end

    repeat (4) @(negedge bick);
    check("missed_stops", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
